// File: rtl/pipelined_control_unit_if.sv
// Control-path bundle between the ID-stage instruction fields / hazard unit
// and the pipelined control unit. The master side owns the instruction fields
// and the hazard requests; the slave side returns the per-stage control bundles.
interface pipelined_control_unit_if;
    logic [4:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_0;
    logic        stall_in;
    logic        flush_in;
    logic [14:0] ex_ctrl;
    logic [14:0] mem_ctrl;
    logic [14:0] wb_ctrl;
    logic [2:0]  ex_funct3;
    logic        stall_out;
    logic        halted;

    modport master (
        output opcode, funct3, funct7_0, stall_in, flush_in,
        input  ex_ctrl, mem_ctrl, wb_ctrl, ex_funct3, stall_out, halted
    );

    modport slave (
        input  opcode, funct3, funct7_0, stall_in, flush_in,
        output ex_ctrl, mem_ctrl, wb_ctrl, ex_funct3, stall_out, halted
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// Pipelined control unit: decodes the ID-stage opcode into a 15-bit control
// bundle and carries it through ID/EX, EX/MEM and MEM/WB with bubble, stall
// and flush handling. A small sequencer holds multi-cycle MUL/DIV ops in EX
// and freezes the front end; ECALL/EBREAK retiring from WB sets a sticky halt.
//
// Bundle map: [0]branch [1]memread [2]memtoreg [3]memwrite [4]alusrc
//             [5]regwrite [6]jalr_jump [7]jal_jump [9:8]regwrite_sel
//             [12:10]aluop [13]muldiv [14]sys_halt. All-zero is a bubble.
module pipelined_control_unit #(
    parameter int MULDIV_EN   = 1,
    parameter int MUL_LATENCY = 1,
    parameter int DIV_LATENCY = 32,
    parameter int HALT_EN     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    pipelined_control_unit_if.slave  bus
);

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_IARITH = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    localparam logic [2:0] ALUOP_LOAD_STORE = 3'b000;
    localparam logic [2:0] ALUOP_BRANCH     = 3'b001;
    localparam logic [2:0] ALUOP_R          = 3'b010;
    localparam logic [2:0] ALUOP_JALR       = 3'b011;
    localparam logic [2:0] ALUOP_I          = 3'b100;
    localparam logic [2:0] ALUOP_MULDIV     = 3'b101;
    localparam logic [2:0] ALUOP_OTHER      = 3'b110;

    localparam logic [7:0] MUL_L = 8'(MUL_LATENCY);
    localparam logic [7:0] DIV_L = 8'(DIV_LATENCY);

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // Opcode/funct decode into the control bundle.
    function automatic logic [14:0] decode(input logic [4:0] op,
                                           input logic [2:0] f3,
                                           input logic       f7);
        logic [14:0] c;
        c = '0;
        case (op)
            OP_R: begin
                c[5] = 1'b1;
                if ((MULDIV_EN != 0) && f7) begin
                    c[13]    = 1'b1;
                    c[12:10] = ALUOP_MULDIV;
                end else begin
                    c[12:10] = ALUOP_R;
                end
            end
            OP_IARITH: begin
                c[4]     = 1'b1;
                c[5]     = 1'b1;
                c[12:10] = ALUOP_I;
            end
            OP_LOAD: begin
                c[1]     = 1'b1;
                c[2]     = 1'b1;
                c[4]     = 1'b1;
                c[5]     = 1'b1;
                c[12:10] = ALUOP_LOAD_STORE;
            end
            OP_STORE: begin
                c[3]     = 1'b1;
                c[4]     = 1'b1;
                c[12:10] = ALUOP_LOAD_STORE;
            end
            OP_BRANCH: begin
                c[0]     = 1'b1;
                c[12:10] = ALUOP_BRANCH;
            end
            OP_JALR: begin
                c[0]     = 1'b1;
                c[4]     = 1'b1;
                c[5]     = 1'b1;
                c[6]     = 1'b1;
                c[9:8]   = 2'b01;
                c[12:10] = ALUOP_JALR;
            end
            OP_JAL: begin
                c[5]     = 1'b1;
                c[7]     = 1'b1;
                c[9:8]   = 2'b01;
                c[12:10] = ALUOP_OTHER;
            end
            OP_LUI: begin
                c[5]   = 1'b1;
                c[9:8] = 2'b10;
            end
            OP_AUIPC: begin
                c[5]   = 1'b1;
                c[9:8] = 2'b11;
            end
            OP_SYSTEM: begin
                // Only ECALL/EBREAK (funct3 == 0) halt; CSR ops decode as bubbles.
                c[14] = (f3 == 3'b000) && (HALT_EN != 0);
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    logic [14:0] ctrl_p0;   // decoded bundle for the instruction in ID
    logic [14:0] ctrl_p1;   // ID/EX
    logic [14:0] ctrl_p2;   // EX/MEM
    logic [14:0] ctrl_p3;   // MEM/WB
    logic [2:0]  f3_p1;
    logic        halted_q;

    md_state_t   state_q, state_n;
    logic [7:0]  cnt_q, cnt_n;
    logic        mark_q, mark_n;
    logic        md_busy;
    logic [7:0]  lat;

    assign ctrl_p0 = decode(bus.opcode, bus.funct3, bus.funct7_0);
    assign lat     = f3_p1[2] ? DIV_L : MUL_L;

    // MUL/DIV sequencer next-state: holds an M op in EX for exactly lat cycles.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        mark_n  = mark_q;
        md_busy = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (ctrl_p1[13] && (lat > 8'd1) && !mark_q) begin
                    md_busy = 1'b1;
                    cnt_n   = lat - 8'd2;
                    if (lat > 8'd2) begin
                        state_n = MD_BUSY;
                    end else begin
                        // Two-cycle op: one stall, then let it go without re-triggering.
                        mark_n = 1'b1;
                    end
                end else if (mark_q) begin
                    // The counted op leaves EX on this edge.
                    mark_n = 1'b0;
                end
            end
            MD_BUSY: begin
                if (cnt_q != 8'd0) begin
                    md_busy = 1'b1;
                    cnt_n   = cnt_q - 8'd1;
                end else begin
                    state_n = MD_IDLE;
                end
            end
            default: state_n = MD_IDLE;
        endcase
    end

    // Sequencer state register; a flush aborts any op in progress.
    always_ff @(posedge clk) begin
        if (rst || bus.flush_in) begin
            state_q <= MD_IDLE;
            cnt_q   <= 8'd0;
            mark_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            mark_q  <= mark_n;
        end
    end

    // Control pipeline: rst > flush > md_busy > stall_in > normal advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_p1 <= '0;
            f3_p1   <= '0;
            ctrl_p2 <= '0;
            ctrl_p3 <= '0;
        end else if (bus.flush_in) begin
            ctrl_p1 <= '0;
            f3_p1   <= '0;
            ctrl_p2 <= '0;
            ctrl_p3 <= ctrl_p2;
        end else if (md_busy) begin
            ctrl_p2 <= '0;
            ctrl_p3 <= ctrl_p2;
        end else if (bus.stall_in) begin
            ctrl_p1 <= '0;
            f3_p1   <= '0;
            ctrl_p2 <= ctrl_p1;
            ctrl_p3 <= ctrl_p2;
        end else begin
            ctrl_p1 <= ctrl_p0;
            f3_p1   <= bus.funct3;
            ctrl_p2 <= ctrl_p1;
            ctrl_p3 <= ctrl_p2;
        end
    end

    // Sticky halt once a system-halt bundle reaches writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else if (ctrl_p3[14] && (HALT_EN != 0)) begin
            halted_q <= 1'b1;
        end
    end

    assign bus.ex_ctrl   = ctrl_p1;
    assign bus.mem_ctrl  = ctrl_p2;
    assign bus.wb_ctrl   = ctrl_p3;
    assign bus.ex_funct3 = f3_p1;
    assign bus.stall_out = md_busy | halted_q;
    assign bus.halted    = halted_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit. Three configurations share one stimulus:
//   dut0: defaults (MUL 1 cycle, DIV 32 cycles, M-ext and halt enabled)
//   dut1: MUL 2 cycles, DIV 3 cycles, halt disabled
//   dut2: M-extension disabled
// A stage-occupancy model predicts every output each cycle; directed literal
// checks pin the model against hand-computed values.
module tb_pipelined_control_unit;

    localparam int CFG_MD   [3] = '{1, 1, 0};
    localparam int CFG_MUL  [3] = '{1, 2, 1};
    localparam int CFG_DIV  [3] = '{32, 3, 32};
    localparam int CFG_HALT [3] = '{1, 0, 1};

    localparam logic [4:0] FENCE = 5'b00011;

    logic       clk;
    logic       rst;
    logic [4:0] opcode;
    logic [2:0] funct3;
    logic       funct7_0;
    logic       stall_in;
    logic       flush_in;

    int n_assert = 0;
    int n_fail   = 0;

    pipelined_control_unit_if bus0 ();
    pipelined_control_unit_if bus1 ();
    pipelined_control_unit_if bus2 ();

    assign bus0.opcode = opcode;  assign bus1.opcode = opcode;  assign bus2.opcode = opcode;
    assign bus0.funct3 = funct3;  assign bus1.funct3 = funct3;  assign bus2.funct3 = funct3;
    assign bus0.funct7_0 = funct7_0; assign bus1.funct7_0 = funct7_0; assign bus2.funct7_0 = funct7_0;
    assign bus0.stall_in = stall_in; assign bus1.stall_in = stall_in; assign bus2.stall_in = stall_in;
    assign bus0.flush_in = flush_in; assign bus1.flush_in = flush_in; assign bus2.flush_in = flush_in;

    pipelined_control_unit #(.MULDIV_EN(1), .MUL_LATENCY(1), .DIV_LATENCY(32), .HALT_EN(1))
        dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    pipelined_control_unit #(.MULDIV_EN(1), .MUL_LATENCY(2), .DIV_LATENCY(3), .HALT_EN(0))
        dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    pipelined_control_unit #(.MULDIV_EN(0), .MUL_LATENCY(1), .DIV_LATENCY(32), .HALT_EN(1))
        dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    logic [14:0] d_ex [3], d_mem [3], d_wb [3];
    logic [2:0]  d_f3 [3];
    logic        d_stall [3], d_halt [3];

    assign d_ex[0] = bus0.ex_ctrl;   assign d_ex[1] = bus1.ex_ctrl;   assign d_ex[2] = bus2.ex_ctrl;
    assign d_mem[0] = bus0.mem_ctrl; assign d_mem[1] = bus1.mem_ctrl; assign d_mem[2] = bus2.mem_ctrl;
    assign d_wb[0] = bus0.wb_ctrl;   assign d_wb[1] = bus1.wb_ctrl;   assign d_wb[2] = bus2.wb_ctrl;
    assign d_f3[0] = bus0.ex_funct3; assign d_f3[1] = bus1.ex_funct3; assign d_f3[2] = bus2.ex_funct3;
    assign d_stall[0] = bus0.stall_out; assign d_stall[1] = bus1.stall_out; assign d_stall[2] = bus2.stall_out;
    assign d_halt[0] = bus0.halted;  assign d_halt[1] = bus1.halted;  assign d_halt[2] = bus2.halted;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // Expected bundle per opcode, written out as hex from the bit map.
    function automatic logic [14:0] exp_decode(int k, logic [4:0] op, logic [2:0] f3, logic f7);
        case (op)
            5'b01100: return (CFG_MD[k] != 0 && f7) ? 15'h3420 : 15'h0820;
            5'b00100: return 15'h1030;
            5'b00000: return 15'h0036;
            5'b01000: return 15'h0018;
            5'b11000: return 15'h0401;
            5'b11001: return 15'h0D71;
            5'b11011: return 15'h19A0;
            5'b01101: return 15'h0220;
            5'b00101: return 15'h0320;
            5'b11100: return (f3 == 3'b000 && CFG_HALT[k] != 0) ? 15'h4000 : 15'h0000;
            default:  return 15'h0000;
        endcase
    endfunction

    logic [14:0] m_ex [3], m_mem [3], m_wb [3];
    logic [2:0]  m_f3 [3];
    int          m_age [3];     // cycles the current EX bundle has spent in EX
    logic        m_halt [3];
    logic        m_bz [3];
    logic        m_valid = 1'b0;

    function automatic logic m_busy(int k);
        int l;
        l = m_f3[k][2] ? CFG_DIV[k] : CFG_MUL[k];
        return m_ex[k][13] && (m_age[k] < l);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) m_bz[k] = m_busy(k);
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_f3[k] = '0;
                m_age[k] = 0; m_halt[k] = 1'b0;
            end else begin
                if (m_wb[k][14]) m_halt[k] = 1'b1;
                m_wb[k] = m_mem[k];
                if (flush_in) begin
                    m_mem[k] = '0; m_ex[k] = '0; m_f3[k] = '0; m_age[k] = 0;
                end else if (m_bz[k]) begin
                    m_mem[k] = '0; m_age[k] = m_age[k] + 1;
                end else if (stall_in) begin
                    m_mem[k] = m_ex[k]; m_ex[k] = '0; m_f3[k] = '0; m_age[k] = 0;
                end else begin
                    m_mem[k] = m_ex[k];
                    m_ex[k]  = exp_decode(k, opcode, funct3, funct7_0);
                    m_f3[k]  = funct3;
                    m_age[k] = 1;
                end
            end
        end
        if (rst) m_valid = 1'b1;
    end

    task automatic cmp(string nm, int k, logic [31:0] act, logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Every cycle, compare all outputs of all configurations with the model.
    always @(negedge clk) begin
        if (m_valid) begin
            for (int k = 0; k < 3; k++) begin
                cmp("model_ex_ctrl", k, 32'(d_ex[k]), 32'(m_ex[k]));
                cmp("model_mem_ctrl", k, 32'(d_mem[k]), 32'(m_mem[k]));
                cmp("model_wb_ctrl", k, 32'(d_wb[k]), 32'(m_wb[k]));
                cmp("model_ex_funct3", k, 32'(d_f3[k]), 32'(m_f3[k]));
                cmp("model_stall_out", k, 32'(d_stall[k]), 32'(m_busy(k) | m_halt[k]));
                cmp("model_halted", k, 32'(d_halt[k]), 32'(m_halt[k]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(logic [4:0] op, logic [2:0] f3, logic f7);
        opcode = op; funct3 = f3; funct7_0 = f7;
    endtask

    initial begin
        rst = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
        put(FENCE, 3'b000, 1'b0);
        tick();
        rst = 1'b0;
        cmp("reset_ex_ctrl", 0, 32'(d_ex[0]), 32'h0);
        cmp("reset_stall_out", 0, 32'(d_stall[0]), 32'h0);
        cmp("reset_halted", 0, 32'(d_halt[0]), 32'h0);

        // addi flows ID -> EX -> MEM
        put(5'b00100, 3'b000, 1'b0);
        tick();
        cmp("addi_ex", 0, 32'(d_ex[0]), 32'h1030);
        put(FENCE, 3'b000, 1'b0);
        tick();
        cmp("addi_mem", 0, 32'(d_mem[0]), 32'h1030);
        cmp("addi_no_stall", 0, 32'(d_stall[0]), 32'h0);

        // lw followed by a one-cycle load-use stall
        put(5'b00000, 3'b010, 1'b0);
        tick();
        cmp("lw_ex", 0, 32'(d_ex[0]), 32'h0036);
        put(5'b00100, 3'b000, 1'b0);
        stall_in = 1'b1;
        tick();
        cmp("stall_bubble_ex", 0, 32'(d_ex[0]), 32'h0);
        cmp("stall_lw_mem", 0, 32'(d_mem[0]), 32'h0036);
        cmp("stall_no_stall_out", 0, 32'(d_stall[0]), 32'h0);
        stall_in = 1'b0;
        tick();
        cmp("after_stall_ex", 0, 32'(d_ex[0]), 32'h1030);
        put(FENCE, 3'b000, 1'b0);
        tick();

        // DIV: 31 stall cycles, then retires to MEM 32 edges after entering EX
        put(5'b01100, 3'b100, 1'b1);
        tick();
        cmp("div_ex", 0, 32'(d_ex[0]), 32'h3420);
        cmp("div_f3", 0, 32'(d_f3[0]), 32'h4);
        cmp("nomd_div_is_r", 2, 32'(d_ex[2]), 32'h0820);
        cmp("nomd_no_stall", 2, 32'(d_stall[2]), 32'h0);
        put(FENCE, 3'b000, 1'b0);
        for (int i = 0; i < 31; i++) begin
            cmp("div_stalling", 0, 32'(d_stall[0]), 32'h1);
            cmp("div_held_ex", 0, 32'(d_ex[0]), 32'h3420);
            cmp("div_mem_bubble", 0, 32'(d_mem[0]), 32'h0);
            tick();
        end
        cmp("div_last_cycle_free", 0, 32'(d_stall[0]), 32'h0);
        tick();
        cmp("div_reaches_mem", 0, 32'(d_mem[0]), 32'h3420);
        tick(); tick();

        // flush in the 5th busy cycle of a DIV
        put(5'b01100, 3'b100, 1'b1);
        tick();
        put(FENCE, 3'b000, 1'b0);
        tick(); tick(); tick(); tick();
        cmp("flush_pre_busy", 0, 32'(d_stall[0]), 32'h1);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        cmp("flush_ex", 0, 32'(d_ex[0]), 32'h0);
        cmp("flush_mem", 0, 32'(d_mem[0]), 32'h0);
        cmp("flush_stall_out", 0, 32'(d_stall[0]), 32'h0);
        put(5'b00100, 3'b000, 1'b0);
        tick();
        cmp("flush_fsm_idle", 0, 32'(d_stall[0]), 32'h0);
        cmp("flush_next_ex", 0, 32'(d_ex[0]), 32'h1030);

        // back-to-back MULs: 1-cycle in dut0, 2-cycle in dut1
        put(5'b01100, 3'b000, 1'b1);
        tick();
        cmp("mul_l1_no_stall", 0, 32'(d_stall[0]), 32'h0);
        cmp("mul_l2_stall", 1, 32'(d_stall[1]), 32'h1);
        tick();
        cmp("mul_l2_release", 1, 32'(d_stall[1]), 32'h0);
        tick();
        cmp("mul_l2_restart", 1, 32'(d_stall[1]), 32'h1);
        put(FENCE, 3'b000, 1'b0);
        tick(); tick(); tick();

        // stall_in asserted while a divide is busy, and together with flush
        put(5'b01100, 3'b110, 1'b1);
        tick();
        put(5'b00000, 3'b010, 1'b0);
        stall_in = 1'b1;
        tick(); tick();
        stall_in = 1'b0;
        tick(); tick();
        stall_in = 1'b1; flush_in = 1'b1;
        tick();
        stall_in = 1'b0; flush_in = 1'b0;
        put(FENCE, 3'b000, 1'b0);
        tick(); tick();

        // remaining opcode classes through the model
        put(5'b01000, 3'b010, 1'b0); tick();
        put(5'b11000, 3'b001, 1'b0); tick();
        put(5'b11001, 3'b000, 1'b0); tick();
        cmp("jalr_ex", 0, 32'(d_ex[0]), 32'h0D71);
        put(5'b11011, 3'b000, 1'b0); tick();
        cmp("jal_ex", 0, 32'(d_ex[0]), 32'h19A0);
        put(5'b01101, 3'b000, 1'b0); tick();
        put(5'b00101, 3'b000, 1'b0); tick();
        put(5'b11100, 3'b001, 1'b0); tick();
        cmp("csr_bubble", 0, 32'(d_ex[0]), 32'h0);
        put(5'b11111, 3'b000, 1'b0); tick();
        put(FENCE, 3'b000, 1'b0); tick(); tick(); tick();

        // reset in the middle of a busy divide
        put(5'b01100, 3'b101, 1'b1);
        tick();
        put(FENCE, 3'b000, 1'b0);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp("rst_busy_ex", 0, 32'(d_ex[0]), 32'h0);
        cmp("rst_busy_mem", 0, 32'(d_mem[0]), 32'h0);
        cmp("rst_busy_wb", 0, 32'(d_wb[0]), 32'h0);
        cmp("rst_busy_stall", 0, 32'(d_stall[0]), 32'h0);
        put(5'b00100, 3'b000, 1'b0);
        tick();
        cmp("rst_fsm_idle", 0, 32'(d_stall[0]), 32'h0);
        put(FENCE, 3'b000, 1'b0);
        tick(); tick();

        // ECALL: halted 4 edges after decode, sticky until rst
        put(5'b11100, 3'b000, 1'b0);
        tick();
        cmp("ecall_ex", 0, 32'(d_ex[0]), 32'h4000);
        cmp("ecall_noh_ex", 1, 32'(d_ex[1]), 32'h0);
        put(FENCE, 3'b000, 1'b0);
        tick();
        tick();
        cmp("ecall_wb", 0, 32'(d_wb[0]), 32'h4000);
        cmp("ecall_not_yet", 0, 32'(d_halt[0]), 32'h0);
        tick();
        cmp("ecall_halted", 0, 32'(d_halt[0]), 32'h1);
        cmp("ecall_stall_out", 0, 32'(d_stall[0]), 32'h1);
        cmp("noh_not_halted", 1, 32'(d_halt[1]), 32'h0);
        put(5'b00100, 3'b000, 1'b0);
        tick();
        cmp("halt_sticky", 0, 32'(d_halt[0]), 32'h1);
        cmp("halt_drains_ex", 0, 32'(d_ex[0]), 32'h1030);
        put(FENCE, 3'b000, 1'b0);
        tick(); tick();
        cmp("halt_still_stall", 0, 32'(d_stall[0]), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp("rst_clears_halt", 0, 32'(d_halt[0]), 32'h0);
        cmp("rst_clears_stall", 0, 32'(d_stall[0]), 32'h0);
        tick(); tick();

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
